// File: rtl/serial_adder.sv
// Chunk-serial add/subtract engine: CHUNK bits per clock, LSB first, with a
// start/busy/done handshake and carry, signed-overflow and zero flags.
module serial_adder #(
    parameter int WIDTH = 4,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] s_next;
    logic             last;
    logic             msb_ovf;

    // Operands shift right each cycle, so the active chunk is always the low CHUNK bits.
    always_comb begin
        sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        s_next = s;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                s_next[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
        last = (cnt == CW'(NCHUNK - 1));
        // Same-sign operands producing an opposite-sign MSB equals carry-in XOR carry-out at the MSB.
        msb_ovf = (a_sh[CHUNK-1] == b_sh[CHUNK-1]) && (sum[CHUNK-1] != a_sh[CHUNK-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= ci ^ sub;
                        cnt   <= '0;
                        s     <= '0;
                        co    <= 1'b0;
                        ovf   <= 1'b0;
                        zero  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    s     <= s_next;
                    carry <= sum[CHUNK];
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        co    <= sum[CHUNK];
                        ovf   <= msb_ovf;
                        zero  <= (s_next == '0);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at several WIDTH/CHUNK settings.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst, start, sub, ci;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;

    logic       busy_c1, done_c1, co_c1, ovf_c1, zero_c1;
    logic       busy_c2, done_c2, co_c2, ovf_c2, zero_c2;
    logic       busy_c4, done_c4, co_c4, ovf_c4, zero_c4;
    logic       busy_w8, done_w8, co_w8, ovf_w8, zero_w8;
    logic [3:0] s_c1, s_c2, s_c4;
    logic [7:0] s_w8;

    int n_cmp = 0;
    int n_bad = 0;
    int lat_c1, lat_c2, lat_c4, lat_w8;
    int nd_c1, nd_c2, nd_c4, nd_w8;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a4), .b(b4), .ci(ci),
        .busy(busy_c1), .done(done_c1), .s(s_c1), .co(co_c1), .ovf(ovf_c1), .zero(zero_c1));
    serial_adder #(.WIDTH(4), .CHUNK(2)) u_c2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a4), .b(b4), .ci(ci),
        .busy(busy_c2), .done(done_c2), .s(s_c2), .co(co_c2), .ovf(ovf_c2), .zero(zero_c2));
    serial_adder #(.WIDTH(4), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a4), .b(b4), .ci(ci),
        .busy(busy_c4), .done(done_c4), .s(s_c4), .co(co_c4), .ovf(ovf_c4), .zero(zero_c4));
    serial_adder #(.WIDTH(8), .CHUNK(4)) u_w8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a8), .b(b8), .ci(ci),
        .busy(busy_w8), .done(done_w8), .s(s_w8), .co(co_w8), .ovf(ovf_w8), .zero(zero_w8));

    // Edge count n: the start edge is 1, so latency is the edge after which done is first seen.
    task automatic sample(input int n);
        if (done_c1) begin nd_c1++; if (lat_c1 == 0) lat_c1 = n; end
        if (done_c2) begin nd_c2++; if (lat_c2 == 0) lat_c2 = n; end
        if (done_c4) begin nd_c4++; if (lat_c4 == 0) lat_c4 = n; end
        if (done_w8) begin nd_w8++; if (lat_w8 == 0) lat_w8 = n; end
    endtask

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb4, input logic tci,
                          input logic tsub, input logic [7:0] ta8, input logic [7:0] tb8);
        a4 = ta; b4 = tb4; ci = tci; sub = tsub; a8 = ta8; b8 = tb8;
        lat_c1 = 0; lat_c2 = 0; lat_c4 = 0; lat_w8 = 0;
        nd_c1 = 0; nd_c2 = 0; nd_c4 = 0; nd_w8 = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sample(1);
        for (int n = 2; n <= 7; n++) begin
            @(posedge clk); #1;
            sample(n);
        end
    endtask

    task automatic wait_done_c1(output int found);
        found = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done_c1) begin found = 1; break; end
        end
    endtask

    function automatic void ref4(input int ta, input int tb4, input int tci, input int tsub,
                                 output logic [3:0] rs, output logic rco,
                                 output logic rovf, output logic rz);
        int u, sa, sb, tru;
        if (tsub == 0) begin
            u = ta + tb4 + tci;
            rco = (u > 15);
        end else begin
            u = ta - tb4 - tci;
            rco = (ta >= tb4 + tci);
        end
        rs = u[3:0];
        sa = (ta > 7) ? ta - 16 : ta;
        sb = (tb4 > 7) ? tb4 - 16 : tb4;
        tru = (tsub == 0) ? sa + sb + tci : sa - sb - tci;
        rovf = (tru > 7) || (tru < -8);
        rz = (rs == 4'd0);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0;
        a4 = 4'hF; b4 = 4'hF; a8 = 8'hFF; b8 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_c1, done_c1, s_c1, co_c1, ovf_c1, zero_c1} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_c1: got busy/done/s/co/ovf/zero=%b expected %b",
                     {busy_c1, done_c1, s_c1, co_c1, ovf_c1, zero_c1}, 9'd0);
        end
        n_cmp++;
        if ({busy_w8, done_w8, s_w8, zero_w8} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_w8: got busy/done/s/zero=%b expected %b",
                     {busy_w8, done_w8, s_w8, zero_w8}, 11'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        run_op(4'b0111, 4'b0001, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({s_c1, co_c1, ovf_c1, zero_c1} !== 7'b1000_0_1_0) begin
            n_bad++;
            $display("FAIL add_ovf: got s/co/ovf/zero=%b expected %b",
                     {s_c1, co_c1, ovf_c1, zero_c1}, 7'b1000_0_1_0);
        end
        n_cmp++;
        if (lat_c1 !== 5) begin
            n_bad++;
            $display("FAIL add_latency: got %0d expected 5", lat_c1);
        end
        n_cmp++;
        if (nd_c1 !== 1) begin
            n_bad++;
            $display("FAIL done_width: got %0d cycles expected 1", nd_c1);
        end
    endtask

    task automatic test_carry_zero();
        run_op(4'b1111, 4'b0001, 1'b1, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({s_c1, co_c1, ovf_c1, zero_c1} !== 7'b0001_1_0_0) begin
            n_bad++;
            $display("FAIL add_carry: got s/co/ovf/zero=%b expected %b",
                     {s_c1, co_c1, ovf_c1, zero_c1}, 7'b0001_1_0_0);
        end
        run_op(4'b1111, 4'b0001, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++;
        if ({s_c1, co_c1, ovf_c1, zero_c1} !== 7'b0000_1_0_1) begin
            n_bad++;
            $display("FAIL add_zero: got s/co/ovf/zero=%b expected %b",
                     {s_c1, co_c1, ovf_c1, zero_c1}, 7'b0000_1_0_1);
        end
    endtask

    task automatic test_sub();
        run_op(4'b0101, 4'b0011, 1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++;
        if ({s_c1, co_c1, ovf_c1, zero_c1} !== 7'b0010_1_0_0) begin
            n_bad++;
            $display("FAIL sub_pos: got s/co/ovf/zero=%b expected %b",
                     {s_c1, co_c1, ovf_c1, zero_c1}, 7'b0010_1_0_0);
        end
        run_op(4'b0011, 4'b0101, 1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++;
        if ({s_c1, co_c1, ovf_c1, zero_c1} !== 7'b1110_0_0_0) begin
            n_bad++;
            $display("FAIL sub_borrow: got s/co/ovf/zero=%b expected %b",
                     {s_c1, co_c1, ovf_c1, zero_c1}, 7'b1110_0_0_0);
        end
        run_op(4'b1000, 4'b0001, 1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++;
        if ({s_c1, co_c1, ovf_c1, zero_c1} !== 7'b0111_1_1_0) begin
            n_bad++;
            $display("FAIL sub_ovf: got s/co/ovf/zero=%b expected %b",
                     {s_c1, co_c1, ovf_c1, zero_c1}, 7'b0111_1_1_0);
        end
    endtask

    task automatic test_ignore_start();
        int found;
        a4 = 4'b0010; b4 = 4'b0011; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({busy_c1, s_c1, co_c1, ovf_c1, zero_c1} !== 8'b1_0000_0_0_0) begin
            n_bad++;
            $display("FAIL start_clear: got busy/s/co/ovf/zero=%b expected %b",
                     {busy_c1, s_c1, co_c1, ovf_c1, zero_c1}, 8'b1_0000_0_0_0);
        end
        repeat (2) @(posedge clk);
        #1;
        a4 = 4'b1111; b4 = 4'b1111; ci = 1'b1; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done_c1(found);
        n_cmp++;
        if (found !== 1) begin
            n_bad++;
            $display("FAIL ignore_done: got found=%0d expected 1", found);
        end
        n_cmp++;
        if ({s_c1, co_c1} !== 5'b0101_0) begin
            n_bad++;
            $display("FAIL ignore_result: got s/co=%b expected %b", {s_c1, co_c1}, 5'b0101_0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_c1 !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_idle: got busy=%b expected 0", busy_c1);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int seen;
        a4 = 4'b0111; b4 = 4'b0000; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_c1, done_c1, s_c1, co_c1} !== 7'd0) begin
            n_bad++;
            $display("FAIL abort_state: got busy/done/s/co=%b expected %b",
                     {busy_c1, done_c1, s_c1, co_c1}, 7'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done_c1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_done: got %0d done pulses expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int found;
        a4 = 4'd1; b4 = 4'd2; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done_c1(found);
        n_cmp++;
        if ({found[0], s_c1} !== 5'b1_0011) begin
            n_bad++;
            $display("FAIL b2b_first: got found/s=%b expected %b", {found[0], s_c1}, 5'b1_0011);
        end
        a4 = 4'd3; b4 = 4'd4;
        @(posedge clk); #1;
        n_cmp++;
        if (busy_c1 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: got busy=%b expected 0", busy_c1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy_c1 !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_restart: got busy=%b expected 1", busy_c1);
        end
        wait_done_c1(found);
        n_cmp++;
        if ({found[0], s_c1} !== 5'b1_0111) begin
            n_bad++;
            $display("FAIL b2b_second: got found/s=%b expected %b", {found[0], s_c1}, 5'b1_0111);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_wide();
        run_op(4'd0, 4'd0, 1'b0, 1'b0, 8'h7F, 8'h01);
        n_cmp++;
        if ({s_w8, co_w8, ovf_w8, zero_w8} !== 11'b1000_0000_0_1_0) begin
            n_bad++;
            $display("FAIL w8_add: got s/co/ovf/zero=%b expected %b",
                     {s_w8, co_w8, ovf_w8, zero_w8}, 11'b1000_0000_0_1_0);
        end
        n_cmp++;
        if (lat_w8 !== 3) begin
            n_bad++;
            $display("FAIL w8_latency: got %0d expected 3", lat_w8);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] rs;
        logic       rco, rovf, rz;
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    for (int c = 0; c < 2; c++) begin
                        run_op(4'(x), 4'(y), c[0], m[0], 8'h00, 8'h00);
                        ref4(x, y, c, m, rs, rco, rovf, rz);
                        n_cmp++;
                        if ({s_c1, co_c1, ovf_c1, zero_c1} !== {rs, rco, rovf, rz}) begin
                            n_bad++;
                            $display("FAIL ex_c1 m=%0d a=%0d b=%0d ci=%0d: got %b expected %b",
                                     m, x, y, c, {s_c1, co_c1, ovf_c1, zero_c1}, {rs, rco, rovf, rz});
                        end
                        n_cmp++;
                        if ({s_c2, co_c2, ovf_c2, zero_c2} !== {rs, rco, rovf, rz}) begin
                            n_bad++;
                            $display("FAIL ex_c2 m=%0d a=%0d b=%0d ci=%0d: got %b expected %b",
                                     m, x, y, c, {s_c2, co_c2, ovf_c2, zero_c2}, {rs, rco, rovf, rz});
                        end
                        n_cmp++;
                        if ({s_c4, co_c4, ovf_c4, zero_c4} !== {rs, rco, rovf, rz}) begin
                            n_bad++;
                            $display("FAIL ex_c4 m=%0d a=%0d b=%0d ci=%0d: got %b expected %b",
                                     m, x, y, c, {s_c4, co_c4, ovf_c4, zero_c4}, {rs, rco, rovf, rz});
                        end
                        n_cmp++;
                        if ({lat_c1, lat_c2, lat_c4} !== {32'd5, 32'd3, 32'd2}) begin
                            n_bad++;
                            $display("FAIL ex_latency: got %0d/%0d/%0d expected 5/3/2",
                                     lat_c1, lat_c2, lat_c4);
                        end
                        n_cmp++;
                        if ({nd_c1, nd_c2, nd_c4} !== {32'd1, 32'd1, 32'd1}) begin
                            n_bad++;
                            $display("FAIL ex_done_count: got %0d/%0d/%0d expected 1/1/1",
                                     nd_c1, nd_c2, nd_c4);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_carry_zero();
        test_sub();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_wide();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, chunk-serial add/subtract unit; successor to the combinational 4-bit adder.
- Processes CHUNK bits per clock from LSB to MSB and carries between chunks in a register.
- Trades latency for area and provides a start/busy/done handshake plus status flags: carry, signed overflow, zero.
- Used as a shared arithmetic engine behind a controller FSM.

Parameters:
- WIDTH, 4, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 1, bits processed per cycle (1 = bit-serial, WIDTH = single-cycle).
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- sub  in  1  0: S=A+B+Ci; 1: S=A-B-Ci
- a  in  WIDTH  operand A, captured on an accepted start
- b  in  WIDTH  operand B, captured on an accepted start
- ci  in  1  carry-in (add) or borrow-in (sub), captured on an accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- s  out  WIDTH  result, held until the next accepted start
- co  out  1  carry-out; in sub mode 1 = no borrow (A >= B+Ci unsigned)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  s == 0

Behaviour:
- Reset: async. State=IDLE; busy=0, done=0, s=0, co=0, ovf=0, zero=0 (zero=0 at reset, not derived). Internal carry and chunk counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge moves to RUN.
  - Latches a and b. If sub=1, B is stored as ~b.
  - Carry register loads ci (add) or ~ci (sub).
  - Counter cleared. s, co, ovf and zero are cleared to 0 at this edge.
- RUN: each edge computes {c, s_chunk} = A_chunk + B_chunk + carry for chunk index cnt.
  - s[cnt*CHUNK +: CHUNK] is written and the carry register is updated; cnt increments.
  - On the edge where cnt == NCHUNK-1: co = final carry; ovf = carry into MSB XOR carry out of MSB; zero is evaluated on the complete result; state moves to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- busy=1 in RUN and DONE, 0 in IDLE.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+NCHUNK. Back-to-back throughput is one operation per NCHUNK+2 cycles.
- start in RUN or DONE is ignored. Operand changes after capture have no effect.
- Partial result bits in s are visible while busy; consumers use s only when done=1 or after done.
- Reset asserted mid-operation aborts immediately to the reset values. No done is issued for the aborted operation.
- Arithmetic is modulo 2^WIDTH. ovf uses the signed interpretation of a, b and s; the sub-mode operand is ~b.

Test Plan:
- WIDTH=4, CHUNK=1: a=0111, b=0001, ci=0, sub=0 -> done 5 cycles after the start edge; s=1000, co=0, ovf=1, zero=0.
- WIDTH=4: a=1111, b=0001, ci=1, add -> s=0001, co=1, ovf=0. Then a=1111, b=0001, ci=0 -> s=0000, co=1, zero=1.
- WIDTH=4 sub: 0101-0011, ci=0 -> s=0010, co=1. Then 0011-0101, ci=0 -> s=1110, co=0, ovf=0. Then 1000-0001 -> s=0111, ovf=1.
- Busy/abort: pulse start again 2 cycles into RUN with different operands -> ignored; result matches the first operands. Separately, assert rst at RUN cycle 2 -> busy=0, s=0, no done pulse.
- Exhaustive: WIDTH=4, CHUNK in {1,2,4}; all a, b, ci in both modes -> s/co match a±b±ci from a reference model. Latency is 5, 3 and 2 cycles respectively.
- WIDTH=8, CHUNK=4: a=0x7F, b=0x01, ci=0, add -> s=0x80, ovf=1, co=0, done at cycle 3.
